// File: rtl/grant_server_if.sv
// grant_server_if: request/grant inputs, per-requester data and the shared
// valid/ready output channel of the grant server, bundled as one port.
// master = environment side (requesters, arbiter, downstream sink).
// slave  = the grant server itself.
interface grant_server_if #(
  parameter int DATA_W = 8
);
  logic              req_0;
  logic              req_1;
  logic              gnt_0;
  logic              gnt_1;
  logic [DATA_W-1:0] data_0;
  logic [DATA_W-1:0] data_1;
  logic              adv_0;
  logic              adv_1;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_owner;
  logic              out_last;
  logic              done_0;
  logic              done_1;
  logic              busy;
  logic              err;

  modport master (
    output req_0, req_1, gnt_0, gnt_1, data_0, data_1, out_ready,
    input  adv_0, adv_1, out_valid, out_data, out_owner, out_last,
           done_0, done_1, busy, err
  );

  modport slave (
    input  req_0, req_1, gnt_0, gnt_1, data_0, data_1, out_ready,
    output adv_0, adv_1, out_valid, out_data, out_owner, out_last,
           done_0, done_1, busy, err
  );
endinterface

// File: rtl/grant_server.sv
// grant_server: serves one fixed-length burst from the granted requester onto
// a shared valid/ready channel, pulses done to that requester, then waits for
// the requester to drop its request before re-arming.
// Optional feature: define GRANT_SERVER_TIMEOUT_EN to abort a burst after
// TIMEOUT consecutive stalled cycles (reported through err with the done pulse).
module grant_server #(
  parameter int DATA_W  = 8,
  parameter int BEATS   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic          clock,
  input  logic          reset,
  grant_server_if.slave bus
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE, HOLD} state_t;

  state_t           state_q;
  logic             owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q;
  logic             last_q;
  logic             busy_q;
  logic             done_0_q;
  logic             done_1_q;

  logic start;
  logic start_owner;
  logic accept;
  logic owner_req;

  // Requester 0 wins when both are eligible in the same cycle.
  assign start       = (bus.gnt_0 && bus.req_0) || (bus.gnt_1 && bus.req_1);
  assign start_owner = !(bus.gnt_0 && bus.req_0);
  assign accept      = valid_q && bus.out_ready;
  assign owner_req   = owner_q ? bus.req_1 : bus.req_0;

`ifdef GRANT_SERVER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_q;
  logic               err_q;
  logic               stall_expire;

  // This stalled cycle is the TIMEOUT-th in a row.
  assign stall_expire = !bus.out_ready && (stall_q == STALL_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // Burst controller: state, owner, beat counter and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_0_q <= 1'b0;
      done_1_q <= 1'b0;
`ifdef GRANT_SERVER_TIMEOUT_EN
      stall_q  <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= XFER;
            owner_q <= start_owner;
            cnt_q   <= '0;
            valid_q <= 1'b1;
            last_q  <= (LAST_CNT == '0);
            busy_q  <= 1'b1;
`ifdef GRANT_SERVER_TIMEOUT_EN
            stall_q <= '0;
`endif
          end
        end
        XFER: begin
          if (accept) begin
`ifdef GRANT_SERVER_TIMEOUT_EN
            stall_q <= '0;
`endif
            if (cnt_q == LAST_CNT) begin
              state_q  <= DONE;
              valid_q  <= 1'b0;
              last_q   <= 1'b0;
              done_0_q <= !owner_q;
              done_1_q <= owner_q;
            end else begin
              cnt_q  <= cnt_q + CNT_W'(1);
              last_q <= ((cnt_q + CNT_W'(1)) == LAST_CNT);
            end
          end
`ifdef GRANT_SERVER_TIMEOUT_EN
          else if (stall_expire) begin
            state_q  <= DONE;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_0_q <= !owner_q;
            done_1_q <= owner_q;
            err_q    <= 1'b1;
            stall_q  <= '0;
          end else begin
            stall_q <= stall_q + STALL_W'(1);
          end
`endif
        end
        DONE: begin
          done_0_q <= 1'b0;
          done_1_q <= 1'b0;
`ifdef GRANT_SERVER_TIMEOUT_EN
          err_q    <= 1'b0;
`endif
          state_q  <= HOLD;
        end
        HOLD: begin
          // A sticky grant must not restart; wait for the owner to let go.
          if (!owner_req) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = owner_q ? bus.data_1 : bus.data_0;
  assign bus.out_owner = owner_q;
  assign bus.out_last  = last_q;
  assign bus.adv_0     = accept && !owner_q;
  assign bus.adv_1     = accept && owner_q;
  assign bus.done_0    = done_0_q;
  assign bus.done_1    = done_1_q;
  assign bus.busy      = busy_q;
`ifdef GRANT_SERVER_TIMEOUT_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule
